// File: rtl/uart_frac_baud_gen_if.sv
// -----------------------------------------------------------------------------
// uart_frac_baud_gen_if
// Divisor reload channel for uart_frac_baud_gen (valid/ready handshake).
//   cfg_valid  master -> slave  new divisor offered, held until cfg_ready
//   cfg_ready  slave  -> master divisor holding register is free
//   cfg_int    master -> slave  integer part of divisor (0 is treated as 1)
//   cfg_frac   master -> slave  fractional part, units of 1/2^FRAC_BITS clock
// -----------------------------------------------------------------------------
interface uart_frac_baud_gen_if #(
  parameter int INT_WIDTH = 16,
  parameter int FRAC_BITS = 4
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [INT_WIDTH-1:0] cfg_int;
  logic [FRAC_BITS-1:0] cfg_frac;

  modport master (output cfg_valid, output cfg_int, output cfg_frac, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_int, input cfg_frac, output cfg_ready);
endinterface

// File: rtl/uart_frac_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_frac_baud_gen
// Fractional baud generator. Produces a one-cycle os_tick at OVERSAMPLE x baud,
// plus mid_tick (bit centre), bit_tick (bit boundary) and a square baud_out.
// The mean os_tick period is div_int + div_frac/2^FRAC_BITS clocks, realised by
// stretching a period by one clock whenever the fractional accumulator carries.
//   clk       system clock
//   reset     synchronous, active-high
//   enable    1 = run, 0 = freeze counters (ticks suppressed)
//   sync      one-cycle pulse restarting the bit phase
//   cfg       divisor reload channel (slave side)
//   os_tick   oversample tick
//   mid_tick  bit-centre tick
//   bit_tick  bit-boundary tick
//   baud_out  square wave at the baud rate
// -----------------------------------------------------------------------------
module uart_frac_baud_gen #(
  parameter int CLOCK_FREQ = 192000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sync,
  uart_frac_baud_gen_if.slave        cfg,
  output logic                       os_tick,
  output logic                       mid_tick,
  output logic                       bit_tick,
  output logic                       baud_out
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  // Reset divisor in fixed point: CLOCK_FREQ * 2^FRAC_BITS / (BAUD_RATE * OVERSAMPLE), truncated.
  localparam longint DIV_SCALED =
    (longint'(CLOCK_FREQ) << FRAC_BITS) / (longint'(BAUD_RATE) * longint'(OVERSAMPLE));
  localparam logic [INT_WIDTH-1:0] DEF_INT_RAW = INT_WIDTH'(DIV_SCALED >> FRAC_BITS);
  localparam logic [INT_WIDTH-1:0] DEF_INT     = (DEF_INT_RAW == '0) ? INT_WIDTH'(1) : DEF_INT_RAW;
  localparam logic [FRAC_BITS-1:0] DEF_FRAC    = FRAC_BITS'(DIV_SCALED);
  localparam logic [OS_W-1:0]      OS_LAST     = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_PRE_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  // One extra bit so a period of div_int + carry never overflows.
  logic [INT_WIDTH:0]   cnt;
  logic [FRAC_BITS-1:0] acc;
  logic                 carry;
  logic [OS_W-1:0]      os_cnt;
  logic [INT_WIDTH-1:0] div_int, held_int;
  logic [FRAC_BITS-1:0] div_frac, held_frac;
  logic                 pending;
  logic                 os_q, mid_q, bit_q, baud_q;

  logic [INT_WIDTH:0]   period_len;
  logic [FRAC_BITS:0]   acc_sum;
  logic                 wrap, bit_edge, mid_edge, apply_now;

  always_comb begin
    period_len = {1'b0, div_int} + {{INT_WIDTH{1'b0}}, carry};
    // ">=" rather than "==": a divisor shrunk while frozen can leave cnt beyond the new period.
    wrap       = (cnt >= period_len - 1'b1);
    acc_sum    = {1'b0, acc} + {1'b0, div_frac};
    bit_edge   = wrap && (os_cnt == OS_LAST);
    mid_edge   = wrap && (os_cnt == OS_PRE_MID);
    // A frozen or re-phased generator has no bit boundary to wait for, so apply at once.
    apply_now  = pending && (!enable || sync || bit_edge);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      os_cnt   <= '0;
      div_int  <= DEF_INT;
      div_frac <= DEF_FRAC;
      pending  <= 1'b0;
      os_q     <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;
      baud_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by conditional overrides; the last
      // assignment in program order wins at the edge, so pulses are single-cycle.
      os_q  <= 1'b0;
      mid_q <= 1'b0;
      bit_q <= 1'b0;

      if (enable && sync) begin
        cnt    <= '0;
        acc    <= '0;
        carry  <= 1'b0;
        os_cnt <= '0;
        baud_q <= 1'b0;
      end else if (enable) begin
        if (wrap) begin
          cnt          <= '0;
          os_q         <= 1'b1;
          {carry, acc} <= acc_sum;
          if (bit_edge) begin
            os_cnt <= '0;
            bit_q  <= 1'b1;
            baud_q <= ~baud_q;
          end else begin
            os_cnt <= os_cnt + 1'b1;
            if (mid_edge) begin
              mid_q  <= 1'b1;
              baud_q <= ~baud_q;
            end
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Overrides the accumulator update above: the new divisor starts from a clean phase.
      if (apply_now) begin
        div_int  <= held_int;
        div_frac <= held_frac;
        acc      <= '0;
        carry    <= 1'b0;
        pending  <= 1'b0;
      end else if (cfg.cfg_valid && !pending) begin
        pending <= 1'b1;
      end
    end
  end

  // NOTE: the holding register is data-only and never read unless pending is set,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (cfg.cfg_valid && !pending && !reset) begin
      held_int  <= (cfg.cfg_int == '0) ? INT_WIDTH'(1) : cfg.cfg_int;
      held_frac <= cfg.cfg_frac;
    end
  end

  assign cfg.cfg_ready = ~pending;

  // Ticks are masked so a pulse registered just before a freeze or reset never escapes.
  assign os_tick  = os_q  & enable & ~reset;
  assign mid_tick = mid_q & enable & ~reset;
  assign bit_tick = bit_q & enable & ~reset;
  assign baud_out = baud_q;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_frac_baud_gen
// Directed scenarios plus randomized enable/sync/reload/reset traffic, compared
// every cycle against a timing model that derives each oversample period from
// the divisor arithmetic (int part + carries of n*frac / 2^FRAC_BITS).
// -----------------------------------------------------------------------------
module tb_uart_frac_baud_gen;

  localparam int OS       = 16;
  localparam int IW       = 16;
  localparam int FB       = 4;
  localparam int FR       = 1 << FB;
  localparam int DEF_INT  = 1;   // 192000 / (9600*16) = 1.25
  localparam int DEF_FRAC = 4;

  logic clk = 1'b0;
  logic rst, en, sy;
  logic os_tick, mid_tick, bit_tick, baud_out;

  uart_frac_baud_gen_if #(.INT_WIDTH(IW), .FRAC_BITS(FB)) cfg_if ();

  uart_frac_baud_gen #(
    .CLOCK_FREQ(192000), .BAUD_RATE(9600), .OVERSAMPLE(OS),
    .INT_WIDTH(IW), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .reset(rst), .enable(en), .sync(sy), .cfg(cfg_if),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick), .baud_out(baud_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int os_times[$], mid_times[$], bit_times[$], rise_times[$];
  logic prev_baud = 1'b0;

  // Reference model state: current divisor, held divisor, clocks elapsed in the
  // current oversample period, and number of periods since the phase origin.
  int m_int, m_frac, h_int, h_frac, m_e, m_n, m_os;
  bit m_pend, m_baud, m_pos, m_pmid, m_pbit, m_xfer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, want, want, cyc);
  endtask

  // Extra clock owed by period n+1: the integer carry of n*frac over 2^FB.
  function automatic int carry_of(input int n, input int f);
    if (n == 0) return 0;
    return (n * f) / FR - ((n - 1) * f) / FR;
  endfunction

  task automatic model_apply();
    m_int  = h_int;
    m_frac = h_frac;
    m_n    = 0;
    m_pend = 1'b0;
  endtask

  task automatic model_update();
    bit was_pend;
    was_pend = m_pend;
    m_xfer = 1'b0; m_pos = 1'b0; m_pmid = 1'b0; m_pbit = 1'b0;
    if (rst) begin
      m_int = DEF_INT; m_frac = DEF_FRAC; m_pend = 1'b0;
      m_e = 0; m_n = 0; m_os = 0; m_baud = 1'b0;
      return;
    end
    if (en && sy) begin
      m_e = 0; m_n = 0; m_os = 0; m_baud = 1'b0;
      if (was_pend) model_apply();
    end else if (!en) begin
      if (was_pend) model_apply();
    end else if (m_e + 1 >= m_int + carry_of(m_n, m_frac)) begin
      m_e = 0; m_pos = 1'b1; m_n++;
      if (m_os == OS - 1) begin
        m_os = 0; m_pbit = 1'b1; m_baud = ~m_baud;
        if (was_pend) model_apply();
      end else begin
        m_os++;
        if (m_os == OS / 2) begin m_pmid = 1'b1; m_baud = ~m_baud; end
      end
    end else begin
      m_e++;
    end
    if (cfg_if.cfg_valid && !was_pend) begin
      h_int  = (cfg_if.cfg_int == '0) ? 1 : int'(cfg_if.cfg_int);
      h_frac = int'(cfg_if.cfg_frac);
      m_pend = 1'b1;
      m_xfer = 1'b1;
    end
  endtask

  task automatic step();
    logic [4:0] exp_vec, dut_vec;
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    exp_vec = {m_baud, m_pbit & en & ~rst, m_pmid & en & ~rst, m_pos & en & ~rst, ~m_pend};
    dut_vec = {baud_out, bit_tick, mid_tick, os_tick, cfg_if.cfg_ready};
    check("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
    if (os_tick)  os_times.push_back(cyc);
    if (mid_tick) mid_times.push_back(cyc);
    if (bit_tick) bit_times.push_back(cyc);
    if (baud_out && !prev_baud) rise_times.push_back(cyc);
    prev_baud = baud_out;
  endtask

  task automatic clear_meas();
    os_times.delete(); mid_times.delete(); bit_times.delete(); rise_times.delete();
  endtask

  function automatic int at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int first_after(input int q[$], input int t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return -1;
  endfunction

  task automatic offer_cfg(input int ival, input int fval);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_int   = IW'(ival);
    cfg_if.cfg_frac  = FB'(fval);
    step();
    check("cfg_ready_low_after_xfer", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k = 0;
    while (cfg_if.cfg_ready !== 1'b1 && k < budget) begin step(); k++; end
    check(tag, 32'(cfg_if.cfg_ready), 1);
  endtask

  // which: 0 = os_tick, 1 = mid_tick, 2 = bit_tick
  task automatic wait_pulse(input string tag, input int which, input int budget);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < budget) begin
      step(); k++;
      seen = (which == 0) ? os_tick : (which == 1) ? mid_tick : bit_tick;
    end
    check(tag, 32'(seen), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c_en, n_os, k, g0, g1;
    bit seen, pre_ready, b0;

    rst = 1'b1; en = 1'b0; sy = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_int = '0; cfg_if.cfg_frac = '0;
    repeat (3) step();
    check("reset_ready", 32'(cfg_if.cfg_ready), 1);
    check("reset_baud", 32'(baud_out), 0);
    check("reset_ticks", 32'({os_tick, mid_tick, bit_tick}), 0);

    // Defaults 1.25: gaps 1,1,1,2; bit and baud period 20.
    rst = 1'b0; en = 1'b1;
    clear_meas();
    repeat (70) step();
    for (int i = 0; i < 8; i++)
      check("t1_os_gap", at(os_times, i + 1) - at(os_times, i), (i % 4 == 3) ? 2 : 1);
    check("t1_bit_period", at(bit_times, 1) - at(bit_times, 0), 20);
    check("t1_baud_period", at(rise_times, 1) - at(rise_times, 0), 20);

    // Integer divisor 10.
    offer_cfg(10, 0);
    wait_ready("t2_apply", 200);
    clear_meas();
    repeat (400) step();
    check("t2_os_gap_a", at(os_times, 1) - at(os_times, 0), 10);
    check("t2_os_gap_b", at(os_times, 5) - at(os_times, 4), 10);
    check("t2_bit_period", at(bit_times, 1) - at(bit_times, 0), 160);
    check("t2_mid_after_bit", first_after(mid_times, at(bit_times, 0)) - at(bit_times, 0), 80);

    // Divisor 3.5: gaps alternate 3/4, 16 ticks span 56 clocks.
    offer_cfg(3, 8);
    wait_ready("t3_apply", 200);
    clear_meas();
    repeat (200) step();
    check("t3_16_ticks", at(os_times, 16) - at(os_times, 0), 56);
    check("t3_bit_period", at(bit_times, 1) - at(bit_times, 0), 56);
    for (int i = 0; i < 4; i++) begin
      g0 = at(os_times, i + 1) - at(os_times, i);
      g1 = at(os_times, i + 2) - at(os_times, i + 1);
      check("t3_gap_pair_sum", g0 + g1, 7);
      check("t3_gap_alternates", 32'(g0 != g1), 1);
    end

    // Reload mid-bit: old divisor until the bit boundary, new period after it.
    wait_pulse("t4_mid_seen", 1, 100);
    clear_meas();
    offer_cfg(5, 0);
    seen = 1'b0; k = 0; pre_ready = 1'b1;
    while (!seen && k < 100) begin
      pre_ready = cfg_if.cfg_ready;
      step(); k++;
      seen = bit_tick;
    end
    check("t4_bit_seen", 32'(seen), 1);
    check("t4_ready_before_apply", 32'(pre_ready), 0);
    check("t4_ready_after_apply", 32'(cfg_if.cfg_ready), 1);
    for (int i = 1; i < os_times.size(); i++)
      check("t4_old_gap_kept", 32'((os_times[i] - os_times[i - 1]) inside {3, 4}), 1);
    t = cyc;
    wait_pulse("t4_next_os", 0, 20);
    check("t4_new_period", cyc - t, 5);

    // sync on the cycle an os_tick is due (divisor 5, tick just seen).
    t = cyc;
    repeat (4) step();
    sy = 1'b1;
    step();
    sy = 1'b0;
    check("t5_no_tick_on_sync", 32'(os_tick), 0);
    check("t5_baud_cleared", 32'(baud_out), 0);
    n_os = 0; seen = 1'b0; k = 0;
    while (!seen && k < 100) begin
      step(); k++;
      if (os_tick) n_os++;
      seen = mid_tick;
    end
    check("t5_mid_seen", 32'(seen), 1);
    check("t5_mid_delay", cyc - t, 45);
    check("t5_os_before_mid", n_os, 8);

    // Freeze 50 cycles mid-bit, then resume on the same phase.
    b0 = baud_out;
    en = 1'b0;
    n_os = 0;
    repeat (50) begin
      step();
      if (os_tick || mid_tick || bit_tick) n_os++;
    end
    check("t6_no_ticks_frozen", n_os, 0);
    check("t6_baud_held", 32'(baud_out), 32'(b0));
    c_en = cyc;
    en = 1'b1;
    wait_pulse("t6_resume_os", 0, 20);
    check("t6_resume_phase", cyc - c_en, 5);

    // Reset mid-bit with a reload pending: everything back to defaults.
    offer_cfg(7, 3);
    repeat (3) step();
    check("t6_pending_held", 32'(cfg_if.cfg_ready), 0);
    rst = 1'b1;
    step();
    check("t6_rst_ticks", 32'({os_tick, mid_tick, bit_tick}), 0);
    check("t6_rst_baud", 32'(baud_out), 0);
    check("t6_rst_ready", 32'(cfg_if.cfg_ready), 1);
    rst = 1'b0;
    clear_meas();
    repeat (60) step();
    for (int i = 0; i < 4; i++)
      check("t6_default_gap", at(os_times, i + 1) - at(os_times, i), (i == 3) ? 2 : 1);
    check("t6_default_bit_period", at(bit_times, 1) - at(bit_times, 0), 20);
    check("t6_pending_dropped", 32'(cfg_if.cfg_ready), 1);

    // cfg_int = 0 behaves as 1: a tick every clock.
    offer_cfg(0, 0);
    wait_ready("t7_apply", 100);
    clear_meas();
    repeat (20) step();
    check("t7_tick_every_cycle", os_times.size(), 20);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 19) != 0);
      sy  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 399) == 0);
      if (!cfg_if.cfg_valid && $urandom_range(0, 29) == 0) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_int   = IW'($urandom_range(0, 6));
        cfg_if.cfg_frac  = FB'($urandom_range(0, FR - 1));
      end
      step();
      if (m_xfer) cfg_if.cfg_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
